regfile_exec_controller: RTL and testbench
==========================================

Name: regfile_exec_controller

Overview:
Multi-cycle execute/writeback sequencer that sits directly upstream of the 16x20-bit register file. It accepts one 20-bit instruction at a time over a valid/ready handshake and drives the register file read addresses. It computes the ALU result from the returned read data and issues a single-cycle register-file write. It is the only writer of the register file.

Parameters:
DATA_W, 20, datapath and register width
ADDR_W, 4, register index width (16 registers)
IMM_W, 8, immediate field width

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
instrValid  in  1  instrData holds a valid instruction
instrData  in  20  instruction word
instrReady  out  1  block can accept an instruction this cycle
regEnable  out  1  register file enable, high whenever not in reset
writeEnable  out  1  register file write strobe
writeRegister  out  4  write address
WriteData  out  20  write data
ReadRegister1  out  4  read address port 1
ReadRegister2  out  4  read address port 2
ReadData1  in  20  register file read data 1 (combinational)
ReadData2  in  20  register file read data 2 (combinational)
busy  out  1  high in any state other than IDLE or HALTED
halted  out  1  HALT executed; sticky until reset

Behaviour:
- Instruction format: opcode[19:16], rd[15:12], rs1[11:8], rs2[7:4]; imm = [7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
  - 6 ADDI: rd = rs1 + sign-extended imm.
  - 7 LDI: rd = zero-extended imm.
  - 8 SHL: rd = rs1 << 1.
  - 9 SHR: rd = rs1 >> 1, logical.
  - F HALT.
  - A-E: treated as NOP.
- Arithmetic: modulo 2^20; carry and borrow are discarded.
- Reset (reset_n=0 at a clock edge) forces:
  - state IDLE; instrReady=1;
  - writeEnable=0; writeRegister, WriteData, ReadRegister1, ReadRegister2 = 0;
  - busy=0; halted=0; regEnable=0.
- Reset wins over every other event, including mid-instruction. No write is issued for an aborted instruction.
- FSM states:
  - IDLE: instrReady=1. If instrValid is high at the edge, latch instrData and go to DECODE. Otherwise stay.
  - DECODE: drive ReadRegister1=rs1 and ReadRegister2=rs2 from the latched word. NOP and A-E go to IDLE. HALT goes to HALTED. All other opcodes go to EXEC.
  - EXEC: read addresses are held. Sample ReadData1/2, compute the result, and register it into WriteData; writeRegister=rd. Go to WB.
  - WB: writeEnable=1 for exactly this cycle. Go to IDLE.
  - HALTED: instrReady=0, halted=1, writeEnable=0. Only reset exits.
- instrReady is 0 in DECODE, EXEC, WB and HALTED.
- Latency: instruction accepted at edge N; register file write commits at edge N+3; next instruction is accepted no earlier than edge N+3.
- Back-to-back dependent instructions need no forwarding: the write commits before the next DECODE.
- writeRegister and WriteData hold their last values outside WB; they are only meaningful when writeEnable=1.
- rd = rs1 = rs2 is legal: operands are sampled in EXEC, before the write.
- instrValid held high while instrReady=0 is ignored. The source must hold instrData until the handshake completes.

Optional Feature:
- Macro: STATUS_FLAGS_EN.
- Defined: adds outputs flagZero, flagNeg and flagCarry, each 1 bit. They update at the WB edge only, from the committed result:
  - zero: result == 0.
  - neg: bit 19.
  - carry: carry-out of ADD/ADDI, or borrow of SUB; 0 for other opcodes.
  - All flags reset to 0.
- Undefined: these ports and their flag registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and IMM_W constants;
  - opcode enum (OP_NOP..OP_HALT);
  - FSM state enum;
  - instruction field bit-position constants.
- One natural sub-module: exec_alu. It is purely combinational: opcode, a, b and imm in; result and carry out. The controller registers its output.

Test Plan:
- Reset then LDI r1,0x05 and LDI r2,0x03 -> writeEnable pulses 3 cycles after each accept, with writeRegister=1/WriteData=0x00005, then 2/0x00003.
- ADD r3,r1,r2 then SUB r4,r2,r1 -> r3=0x00008; r4=0xFFFFE (wrap).
- ADDI r5,r1,0xFF -> r5=0x00004 (sign-extended -1). SHL of 0x80000 -> 0x00000.
- Hold instrValid high continuously with 3 instructions -> instrReady pulses every 4 cycles; exactly 3 writes; no instruction lost or duplicated.
- NOP then HALT then a valid LDI -> no write for NOP; halted=1; instrReady stays 0; LDI never accepted until reset.
- Assert reset_n=0 during EXEC of an ADD -> no writeEnable pulse; all outputs at reset values next cycle; first post-reset instruction executes normally.

Source files
------------

// File: rtl/regfile_exec_controller_pkg.sv
// Shared constants, opcode/state enums and instruction field positions for the
// execute/writeback sequencer in front of the 16x20 register file.
package regfile_exec_controller_pkg;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int IMM_W  = 8;
    localparam int OPC_W  = 4;

    // Instruction word: opcode[19:16] rd[15:12] rs1[11:8] rs2[7:4], imm overlays [7:0]
    localparam int OPC_LSB = 16;
    localparam int RD_LSB  = 12;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LDI  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALTED
    } state_e;

    // Opcodes that produce a register-file write; A-E fall outside and act as NOP.
    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/regfile_exec_controller_exec_alu.sv
// Combinational ALU for the execute stage; carry is the 21st bit of the
// widened operation (carry-out for ADD/ADDI, borrow for SUB, 0 otherwise).
module exec_alu
    import regfile_exec_controller_pkg::*;
(
    input  logic [OPC_W-1:0]  op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_zx;

    assign imm_sx = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign imm_zx = {{(DATA_W-IMM_W){1'b0}}, imm_i};

    always_comb begin
        wide = '0;
        case (op_i)
            OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  wide = {1'b0, a_i & b_i};
            OP_OR:   wide = {1'b0, a_i | b_i};
            OP_XOR:  wide = {1'b0, a_i ^ b_i};
            OP_ADDI: wide = {1'b0, a_i} + {1'b0, imm_sx};
            OP_LDI:  wide = {1'b0, imm_zx};
            OP_SHL:  wide = {2'b00, a_i[DATA_W-2:0], 1'b0};
            OP_SHR:  wide = {2'b00, a_i[DATA_W-1:1]};
            default: wide = '0;
        endcase
    end

    assign result_o = wide[DATA_W-1:0];
    assign carry_o  = wide[DATA_W];

endmodule

// File: rtl/regfile_exec_controller.sv
// Multi-cycle execute/writeback sequencer, sole writer of the register file.
// Optional STATUS_FLAGS_EN adds zero/neg/carry flags updated at the WB edge.
module regfile_exec_controller
    import regfile_exec_controller_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instrValid,
    input  logic [DATA_W-1:0] instrData,
    output logic              instrReady,
    output logic              regEnable,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              busy,
    output logic              halted
`ifdef STATUS_FLAGS_EN
  , output logic              flagZero,
    output logic              flagNeg,
    output logic              flagCarry
`endif
);

    state_e            state_q;
    logic [OPC_W-1:0]  op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [IMM_W-1:0]  imm_q;
    logic              ready_q;
    logic              regen_q;
    logic              we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] rreg1_q;
    logic [ADDR_W-1:0] rreg2_q;
    logic              busy_q;
    logic              halted_q;

    logic [DATA_W-1:0] res_d;
    logic              carry_d;

    exec_alu u_alu (
        .op_i     (op_q),
        .a_i      (ReadData1),
        .b_i      (ReadData2),
        .imm_i    (imm_q),
        .result_o (res_d),
        .carry_o  (carry_d)
    );

    // Read addresses are captured straight from the accepted word so they are
    // already stable during DECODE and held through EXEC.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            ready_q  <= 1'b1;
            regen_q  <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            rreg1_q  <= '0;
            rreg2_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            regen_q <= 1'b1;
            we_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instrValid) begin
                        op_q    <= instrData[OPC_LSB +: OPC_W];
                        rd_q    <= instrData[RD_LSB  +: ADDR_W];
                        imm_q   <= instrData[IMM_LSB +: IMM_W];
                        rreg1_q <= instrData[RS1_LSB +: ADDR_W];
                        rreg2_q <= instrData[RS2_LSB +: ADDR_W];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (op_q == OP_HALT) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALTED;
                    end else if (is_alu_op(op_q)) begin
                        state_q <= ST_EXEC;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    wdata_q <= res_d;
                    wreg_q  <= rd_q;
                    we_q    <= 1'b1;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instrReady    = ready_q;
    assign regEnable     = regen_q;
    assign writeEnable   = we_q;
    assign writeRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign ReadRegister1 = rreg1_q;
    assign ReadRegister2 = rreg2_q;
    assign busy          = busy_q;
    assign halted        = halted_q;

`ifdef STATUS_FLAGS_EN
    logic carry_q;
    logic fz_q;
    logic fn_q;
    logic fc_q;

    // Carry is captured alongside the result so flags reflect the committed write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            if (state_q == ST_EXEC) begin
                carry_q <= carry_d;
            end
            if (state_q == ST_WB) begin
                fz_q <= (wdata_q == '0);
                fn_q <= wdata_q[DATA_W-1];
                fc_q <= carry_q;
            end
        end
    end

    assign flagZero  = fz_q;
    assign flagNeg   = fn_q;
    assign flagCarry = fc_q;
`else
    logic carry_unused;
    assign carry_unused = carry_d;
`endif

endmodule

// File: tb/tb_regfile_exec_controller.sv
// Randomized bench for regfile_exec_controller: a behavioural model applies each
// accepted instruction to a shadow register file and predicts the write and its edge.
module tb_regfile_exec_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instrValid;
    logic [19:0] instrData;
    logic        instrReady;
    logic        regEnable;
    logic        writeEnable;
    logic [3:0]  writeRegister;
    logic [19:0] WriteData;
    logic [3:0]  ReadRegister1;
    logic [3:0]  ReadRegister2;
    logic [19:0] ReadData1;
    logic [19:0] ReadData2;
    logic        busy;
    logic        halted;

    regfile_exec_controller dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instrValid    (instrValid),
        .instrData     (instrData),
        .instrReady    (instrReady),
        .regEnable     (regEnable),
        .writeEnable   (writeEnable),
        .writeRegister (writeRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .busy          (busy),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    // Register file the DUT drives
    logic [19:0] rf [16];
    assign ReadData1 = rf[ReadRegister1];
    assign ReadData2 = rf[ReadRegister2];
    always @(posedge clock) if (writeEnable) rf[writeRegister] <= WriteData;

    typedef struct {
        int          cyc;
        logic [3:0]  rd;
        logic [19:0] val;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [19:0] pend[$];
    int          acc_q[$];
    logic [19:0] mdl_rf [16];
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Sequential-semantics reference: each instruction sees all earlier results.
    task automatic model(input logic [19:0] ins, input int acc);
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [19:0] a, b, r;
        logic [7:0]  imm;
        bit          w;
        op  = ins[19:16];
        rd  = ins[15:12];
        a   = mdl_rf[ins[11:8]];
        b   = mdl_rf[ins[7:4]];
        imm = ins[7:0];
        w   = 1;
        r   = '0;
        case (op)
            4'h1: r = a + b;
            4'h2: r = a - b;
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = a + {{12{imm[7]}}, imm};
            4'h7: r = {12'h000, imm};
            4'h8: r = a << 1;
            4'h9: r = a >> 1;
            default: w = 0;
        endcase
        if (w) begin
            mdl_rf[rd] = r;
            exp_q.push_back('{acc + 3, rd, r});
        end
    endtask

    task automatic drive_src();
        if (pend.size() > 0) begin
            instrValid = 1'b1;
            instrData  = pend[0];
        end else begin
            instrValid = 1'b0;
            instrData  = 20'($urandom);
        end
    endtask

    task automatic tick();
        bit acc_now;
        acc_now = reset_n && instrValid && instrReady;
        @(posedge clock);
        #1;
        cyc++;
        if (acc_now) begin
            logic [19:0] ins;
            ins = pend.pop_front();
            acc_q.push_back(cyc);
            model(ins, cyc);
        end
        if (writeEnable) obs_q.push_back('{cyc + 1, writeRegister, WriteData});
        drive_src();
    endtask

    task automatic push(input logic [19:0] ins);
        pend.push_back(ins);
        drive_src();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (pend.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(pend.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_cyc"}, 32'(o.cyc), 32'(e.cyc));
            chk({tag, "_rd"},  32'(o.rd),  32'(e.rd));
            chk({tag, "_val"}, 32'(o.val), 32'(e.val));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},  32'(instrReady),    32'd1);
        chk({tag, "_ren"},  32'(regEnable),     32'd0);
        chk({tag, "_we"},   32'(writeEnable),   32'd0);
        chk({tag, "_wreg"}, 32'(writeRegister), 32'd0);
        chk({tag, "_wd"},   32'(WriteData),     32'd0);
        chk({tag, "_rr1"},  32'(ReadRegister1), 32'd0);
        chk({tag, "_rr2"},  32'(ReadRegister2), 32'd0);
        chk({tag, "_busy"}, 32'(busy),          32'd0);
        chk({tag, "_halt"}, 32'(halted),        32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 16; i++) begin
            rf[i]     = 20'($urandom);
            mdl_rf[i] = rf[i];
        end
        reset_n    = 1'b0;
        instrValid = 1'b0;
        instrData  = '0;
        repeat (2) tick();
        chk_reset_outs("rst");
        reset_n = 1'b1;
        tick();
        chk("regen_up", 32'(regEnable), 32'd1);

        // LDI pair, back to back
        acc_q.delete();
        push(20'h71005);
        push(20'h72003);
        drain("ldi");
        compare("ldi");
        chk("ldi_gap", 32'(acc_q[1] - acc_q[0]), 32'd4);

        // ADD / SUB with wrap
        push(20'h13120);
        push(20'h24210);
        drain("addsub");
        compare("addsub");
        chk("add_r3", 32'(rf[3]), 32'h00008);
        chk("sub_r4", 32'(rf[4]), 32'hFFFFE);

        // ADDI with negative imm, SHL dropping the top bit
        rf[6]     = 20'h80000;
        mdl_rf[6] = 20'h80000;
        push(20'h651FF);
        push(20'h87600);
        drain("addi_shl");
        compare("addi_shl");
        chk("addi_r5", 32'(rf[5]), 32'h00004);
        chk("shl_r7",  32'(rf[7]), 32'h00000);

        // Valid held high across three instructions
        acc_q.delete();
        push(20'h7A011);
        push(20'h1BA10);
        push(20'h3CBA0);
        drain("held");
        compare("held");
        chk("held_nacc", 32'(acc_q.size()), 32'd3);
        chk("held_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
        chk("held_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);

        // Random traffic, HALT excluded, with random idle gaps
        for (int i = 0; i < 60; i++) begin
            logic [19:0] ins;
            ins = 20'($urandom);
            ins[19:16] = 4'($urandom_range(0, 14));
            push(ins);
            if ($urandom_range(0, 1) == 0) begin
                int n;
                n = 0;
                while (pend.size() > 0 && n < 50) begin
                    tick();
                    n++;
                end
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        drain("rnd");
        compare("rnd");

        // NOP, HALT, then an LDI that must never be taken
        acc_q.delete();
        push(20'h00000);
        push(20'hF0000);
        push(20'h7D055);
        repeat (30) tick();
        compare("halt");
        chk("halt_nacc",  32'(acc_q.size()), 32'd2);
        chk("halt_gap",   32'(acc_q[1] - acc_q[0]), 32'd2);
        chk("halt_flag",  32'(halted), 32'd1);
        chk("halt_rdy",   32'(instrReady), 32'd0);
        chk("halt_busy",  32'(busy), 32'd0);
        chk("halt_pend",  32'(pend.size()), 32'd1);
        reset_n = 1'b0;
        pend.delete();
        drive_src();
        tick();
        chk_reset_outs("hrst");
        reset_n = 1'b1;
        tick();

        // Reset landing on EXEC of an ADD aborts its write
        begin
            logic [19:0] old8;
            int n;
            old8 = mdl_rf[8];
            acc_q.delete();
            push(20'h18120);
            n = 0;
            while (acc_q.size() == 0 && n < 20) begin
                tick();
                n++;
            end
            chk("abort_acc", 32'(acc_q.size()), 32'd1);
            tick();
            chk("abort_busy", 32'(busy), 32'd1);
            reset_n = 1'b0;
            tick();
            chk_reset_outs("arst");
            void'(exp_q.pop_back());
            mdl_rf[8] = old8;
            reset_n = 1'b1;
            repeat (3) tick();
            compare("abort");
        end
        push(20'h7902A);
        drain("post");
        compare("post");
        chk("post_r9", 32'(rf[9]), 32'h0002A);

        for (int i = 0; i < 16; i++) chk($sformatf("rf%0d", i), 32'(rf[i]), 32'(mdl_rf[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
